// File: rtl/cam_capture_win.sv
// Purpose: DVP camera capture; assembles BYTES_PER_PIX bus words into a pixel, skips start-up frames, crops a window.
// Latency: pixel and markers appear 2 ov5640_pclk cycles after the edge that samples the pixel's final byte.
// Backpressure: none; the camera cannot be stalled, so the consumer must accept one pixel per pix_valid strobe.
//
// Ports:
//   ov5640_pclk / sys_rst_n        : pixel clock, async active-low reset
//   ov5640_href/vsync/data         : raw DVP bus (registered once on entry)
//   capture_en                     : capture request, sampled at frame start only
//   win_x_start/y_start/width/height : crop window, latched at frame start
//   test_pat_en                    : selects the coordinate test pattern (needs CAM_TEST_PATTERN_EN)
//   init_done                      : start-up frame skip finished
//   pix_valid/data/sof/eol/eof     : cropped pixel stream with frame/line markers
//   frame_err                      : pulse when a frame ends before its last window pixel
//   line_err                       : sticky, a line ended on a partial pixel
// Optional feature macro: CAM_TEST_PATTERN_EN

module cam_capture_win #(
    parameter int DATA_IN_W     = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int PIX_W         = DATA_IN_W * BYTES_PER_PIX,
    parameter int CNT_W         = 12,
    parameter int FRAME_SKIP    = 10
) (
    input  logic                 ov5640_pclk,
    input  logic                 sys_rst_n,
    input  logic                 ov5640_href,
    input  logic                 ov5640_vsync,
    input  logic [DATA_IN_W-1:0] ov5640_data,
    input  logic                 capture_en,
    input  logic [CNT_W-1:0]     win_x_start,
    input  logic [CNT_W-1:0]     win_y_start,
    input  logic [CNT_W-1:0]     win_width,
    input  logic [CNT_W-1:0]     win_height,
    input  logic                 test_pat_en,
    output logic                 init_done,
    output logic                 pix_valid,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 pix_eof,
    output logic                 frame_err,
    output logic                 line_err
);

    localparam int BC_W   = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int SKIP_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(BYTES_PER_PIX - 1);
    localparam logic [SKIP_W-1:0] SKIP_N  = SKIP_W'(FRAME_SKIP);
    localparam logic [CNT_W:0]    ONE_X   = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        ST_SKIP     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t state;

    // Input registers and second stage for edge detection
    logic                 href_d, vs_d, href_d2, vs_d2;
    logic [DATA_IN_W-1:0] data_d;

    logic [SKIP_W-1:0] skip_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]  x_cnt, y_cnt;
    logic [CNT_W-1:0]  win_xs_q, win_ys_q, win_w_q, win_h_q;
    logic              eof_done;

    // Pipeline stage between pixel completion and the output register
    logic              s1_vld, s1_sof, s1_eol, s1_eof, s1_ferr;
    logic [PIX_W-1:0]  s1_dat;

    logic             vs_rise, vs_fall, href_fall;
    logic             byte_en, pix_done, in_win, hit;
    logic             at_sof, at_eol, at_eof, eof_now, ferr_now;
    logic [CNT_W:0]   x_ext, y_ext, xs_ext, ys_ext, x_end, y_end;
    logic [PIX_W-1:0] pix_asm, pix_nxt;

    assign vs_rise   = vs_d & ~vs_d2;
    assign vs_fall   = ~vs_d & vs_d2;
    assign href_fall = ~href_d & href_d2;

    assign byte_en  = (state == ST_ACTIVE) && href_d;
    assign pix_done = byte_en && (byte_cnt == BC_LAST);

    // One extra bit so x_start + width never wraps
    assign x_ext  = {1'b0, x_cnt};
    assign y_ext  = {1'b0, y_cnt};
    assign xs_ext = {1'b0, win_xs_q};
    assign ys_ext = {1'b0, win_ys_q};
    assign x_end  = xs_ext + {1'b0, win_w_q};
    assign y_end  = ys_ext + {1'b0, win_h_q};

    assign in_win  = (x_ext >= xs_ext) && (x_ext < x_end) && (y_ext >= ys_ext) && (y_ext < y_end);
    assign hit     = pix_done && in_win;
    assign at_sof  = (x_cnt == win_xs_q) && (y_cnt == win_ys_q);
    assign at_eol  = (x_ext == x_end - ONE_X);
    assign at_eof  = at_eol && (y_ext == y_end - ONE_X);
    assign eof_now = hit && at_eof;

    // A pixel completing in the vs_rise cycle counts toward eof_done
    assign ferr_now = (state == ST_ACTIVE) && vs_rise && !eof_done && !eof_now &&
                      (win_w_q != '0) && (win_h_q != '0);

    // Byte shifter: earlier bytes move toward the MSB, the current bus byte lands in the LSB
    generate
        if (BYTES_PER_PIX > 1) begin : g_shift
            logic [PIX_W-DATA_IN_W-1:0] pix_sh;
            assign pix_asm = {pix_sh, data_d};
            always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    pix_sh <= '0;
                end else if (byte_en) begin
                    pix_sh <= pix_asm[PIX_W-DATA_IN_W-1:0];
                end
            end
        end else begin : g_noshift
            assign pix_asm = data_d;
        end
    endgenerate

`ifdef CAM_TEST_PATTERN_EN
    logic [CNT_W-1:0] pat_val;
    assign pat_val = (x_cnt - win_xs_q) ^ ((y_cnt - win_ys_q) << 4);
    assign pix_nxt = test_pat_en ? PIX_W'(pat_val) : pix_asm;
`else
    logic unused_test_pat;
    assign unused_test_pat = test_pat_en;
    assign pix_nxt = pix_asm;
`endif

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            href_d    <= 1'b0;
            vs_d      <= 1'b0;
            href_d2   <= 1'b0;
            vs_d2     <= 1'b0;
            data_d    <= '0;
            state     <= ST_SKIP;
            skip_cnt  <= '0;
            byte_cnt  <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            win_xs_q  <= '0;
            win_ys_q  <= '0;
            win_w_q   <= '0;
            win_h_q   <= '0;
            eof_done  <= 1'b0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_ferr   <= 1'b0;
            init_done <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            frame_err <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            href_d  <= ov5640_href;
            vs_d    <= ov5640_vsync;
            data_d  <= ov5640_data;
            href_d2 <= href_d;
            vs_d2   <= vs_d;

            s1_vld  <= hit;
            s1_dat  <= hit ? pix_nxt : '0;
            s1_sof  <= hit && at_sof;
            s1_eol  <= hit && at_eol;
            s1_eof  <= eof_now;
            s1_ferr <= ferr_now;

            pix_valid <= s1_vld;
            pix_data  <= s1_dat;
            pix_sof   <= s1_sof;
            pix_eol   <= s1_eol;
            pix_eof   <= s1_eof;
            frame_err <= s1_ferr;

            case (state)
                ST_SKIP: begin
                    if (skip_cnt == SKIP_N) begin
                        state     <= ST_WAIT_SOF;
                        init_done <= 1'b1;
                    end else if (vs_rise) begin
                        skip_cnt <= skip_cnt + SKIP_W'(1);
                    end
                end
                ST_WAIT_SOF: begin
                    if (vs_fall && capture_en) begin
                        win_xs_q <= win_x_start;
                        win_ys_q <= win_y_start;
                        win_w_q  <= win_width;
                        win_h_q  <= win_height;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        byte_cnt <= '0;
                        line_err <= 1'b0;
                        eof_done <= 1'b0;
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (byte_en) begin
                        byte_cnt <= pix_done ? '0 : byte_cnt + BC_W'(1);
                    end
                    if (pix_done && (x_cnt != '1)) begin
                        x_cnt <= x_cnt + CNT_W'(1);
                    end
                    // href_d is low here, so no byte competes with the line reset
                    if (href_fall) begin
                        x_cnt    <= '0;
                        byte_cnt <= '0;
                        if (y_cnt != '1) begin
                            y_cnt <= y_cnt + CNT_W'(1);
                        end
                        if (byte_cnt != '0) begin
                            line_err <= 1'b1;
                        end
                    end
                    if (eof_now) begin
                        eof_done <= 1'b1;
                    end
                    if (vs_rise) begin
                        state <= ST_WAIT_SOF;
                    end
                end
                default: state <= ST_SKIP;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_win.sv
// Purpose: self-checking bench for cam_capture_win (RGB565, two skipped frames).
// Latency: checks the 2-cycle byte-to-pixel delay on the first captured pixel.
// Backpressure: none; the bench collects every pix_valid strobe into queues.

module tb_cam_capture_win;

    localparam int CW = 12;
    localparam int NTV = 14;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            href = 1'b0;
    logic            vsync = 1'b0;
    logic [7:0]      data = 8'h00;
    logic            cap_en = 1'b0;
    logic [CW-1:0]   wxs = '0, wys = '0, ww = '0, wh = '0;
    logic            tpe = 1'b0;
    logic            init_done, pix_valid, pix_sof, pix_eol, pix_eof, frame_err, line_err;
    logic [15:0]     pix_data;

    cam_capture_win #(
        .DATA_IN_W(8), .BYTES_PER_PIX(2), .CNT_W(CW), .FRAME_SKIP(2)
    ) dut (
        .ov5640_pclk(clk), .sys_rst_n(rst_n),
        .ov5640_href(href), .ov5640_vsync(vsync), .ov5640_data(data),
        .capture_en(cap_en),
        .win_x_start(wxs), .win_y_start(wys), .win_width(ww), .win_height(wh),
        .test_pat_en(tpe),
        .init_done(init_done), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .frame_err(frame_err), .line_err(line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // npix/eof/ferr/lerr = -1 means "take the expectation from the model"
    typedef struct {
        int xs, ys, w, h, nlines, lbytes, short_y, short_len, cap, pat, npix, eof, ferr, lerr;
    } vec_t;
    vec_t tv[NTV];

    logic [7:0] fb [4][16];
    int         llen [4];
    int         cur_lines;

    logic [15:0] q_dat[$];
    bit          q_sof[$], q_eol[$], q_eof[$];
    int          n_ferr, n_badmark, t_first_v, t_b1;

    logic [15:0] m_dat[$];
    bit          m_sof[$], m_eol[$], m_eof[$];
    int          m_eofcnt, m_ferr, m_lerr;

    int n_chk = 0, n_fail = 0;

    always @(negedge clk) begin
        if (pix_valid) begin
            q_dat.push_back(pix_data);
            q_sof.push_back(pix_sof);
            q_eol.push_back(pix_eol);
            q_eof.push_back(pix_eof);
            if (t_first_v < 0) t_first_v = cyc;
        end else if (pix_sof || pix_eol || pix_eof) begin
            n_badmark++;
        end
        if (frame_err) n_ferr++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_col();
        q_dat.delete(); q_sof.delete(); q_eol.delete(); q_eof.delete();
        n_ferr = 0;
        t_first_v = -1;
    endtask

    task automatic gen_frame(input int i);
        logic [15:0] p;
        p = 16'(tv[i].pat);
        cur_lines = tv[i].nlines;
        for (int y = 0; y < cur_lines; y++) begin
            llen[y] = (y == tv[i].short_y) ? tv[i].short_len : tv[i].lbytes;
            for (int b = 0; b < llen[y]; b++)
                fb[y][b] = (tv[i].pat != 0) ? ((b % 2 == 0) ? p[15:8] : p[7:0])
                                            : 8'($urandom_range(0, 255));
        end
    endtask

    // Expected stream derived from the window rules on whole pixels of each line
    task automatic build_model(input int i);
        int xs, ys, w, h;
        m_dat.delete(); m_sof.delete(); m_eol.delete(); m_eof.delete();
        m_eofcnt = 0; m_lerr = 0;
        xs = tv[i].xs; ys = tv[i].ys; w = tv[i].w; h = tv[i].h;
        if (tv[i].cap != 0) begin
            for (int y = 0; y < cur_lines; y++) begin
                if (llen[y] % 2 != 0) m_lerr = 1;
                for (int x = 0; x < llen[y] / 2; x++) begin
                    if (x >= xs && x < xs + w && y >= ys && y < ys + h) begin
                        m_dat.push_back({fb[y][2*x], fb[y][2*x+1]});
                        m_sof.push_back(x == xs && y == ys);
                        m_eol.push_back(x == xs + w - 1);
                        m_eof.push_back(x == xs + w - 1 && y == ys + h - 1);
                        if (x == xs + w - 1 && y == ys + h - 1) m_eofcnt++;
                    end
                end
            end
        end
        m_ferr = (tv[i].cap != 0 && w > 0 && h > 0 && m_eofcnt == 0) ? 1 : 0;
    endtask

    task automatic send_lines();
        for (int y = 0; y < cur_lines; y++) begin
            for (int b = 0; b < llen[y]; b++) begin
                href = 1'b1;
                data = fb[y][b];
                if (y == 0 && b == 1) t_b1 = cyc + 1;
                tick();
            end
            href = 1'b0;
            data = 8'h00;
            repeat (4) tick();
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (5) tick();
    endtask

    task automatic set_win(input int i);
        if (i < NTV) begin
            wxs = CW'(tv[i].xs); wys = CW'(tv[i].ys);
            ww = CW'(tv[i].w);   wh = CW'(tv[i].h);
            cap_en = (tv[i].cap != 0);
        end else begin
            wxs = '0; wys = '0; ww = CW'(4); wh = CW'(2);
            cap_en = 1'b1;
        end
    endtask

    function automatic int count_eof();
        int n = 0;
        foreach (q_eof[k]) if (q_eof[k]) n++;
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                xs ys w  h  nl lb sy sl cap pat       npix eof ferr lerr
        tv[0] = '{0, 0, 4, 2, 2, 8, -1, 0, 1, 0,        8, 1, 0, 0};
        tv[1] = '{1, 1, 2, 1, 2, 8, -1, 0, 1, 'hAA55,   2, 1, 0, 0};
        tv[2] = '{3, 0, 1, 1, 2, 8, -1, 0, 1, 0,        1, 1, 0, 0};
        tv[3] = '{0, 0, 0, 2, 2, 8, -1, 0, 1, 0,        0, 0, 0, 0};
        tv[4] = '{0, 0, 4, 3, 2, 8, -1, 0, 1, 0,        8, 0, 1, 0};
        tv[5] = '{2, 0, 4, 2, 2, 8, -1, 0, 1, 0,        4, 0, 1, 0};
        tv[6] = '{0, 0, 4, 2, 2, 8,  0, 3, 1, 0,        5, 1, 0, 1};
        tv[7] = '{0, 0, 4, 2, 2, 8, -1, 0, 1, 0,        8, 1, 0, 0};
        tv[8] = '{0, 0, 4, 2, 2, 8, -1, 0, 0, 0,        0, 0, 0, 0};
        tv[9] = '{1, 0, 2, 3, 3, 10, -1, 0, 1, 0,       6, 1, 0, 0};
        for (int i = 10; i < NTV; i++) begin
            tv[i] = '{$urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 5),
                      $urandom_range(0, 3), 3, 10,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1,
                      2 * $urandom_range(0, 4) + 1, 1, 0, -1, -1, -1, -1};
        end

        clear_col();
        n_badmark = 0;
        repeat (3) tick();
        chk("reset_init_done", int'(init_done), 0);
        chk("reset_pix_valid", int'(pix_valid), 0);
        chk("reset_pix_data", int'(pix_data), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_line_err", int'(line_err), 0);
        rst_n = 1'b1;
        tick();

        // Two start-up frames are discarded
        gen_frame(0); send_lines(); set_win(0); vs_pulse();
        chk("skip1_init_done", int'(init_done), 0);
        gen_frame(0); send_lines(); set_win(0); vs_pulse();
        chk("skip2_init_done", int'(init_done), 1);
        chk("skip_no_pixels", q_dat.size(), 0);

        for (int i = 0; i < NTV; i++) begin
            clear_col();
            cap_en = 1'b1;
            gen_frame(i);
            build_model(i);
            send_lines();
            chk($sformatf("v%0d_line_err", i), int'(line_err), (tv[i].lerr >= 0) ? tv[i].lerr : m_lerr);
            set_win(i + 1);
            vs_pulse();
            chk($sformatf("v%0d_npix", i), q_dat.size(), (tv[i].npix >= 0) ? tv[i].npix : m_dat.size());
            chk($sformatf("v%0d_eof", i), count_eof(), (tv[i].eof >= 0) ? tv[i].eof : m_eofcnt);
            chk($sformatf("v%0d_frame_err", i), n_ferr, (tv[i].ferr >= 0) ? tv[i].ferr : m_ferr);
            for (int k = 0; k < q_dat.size() && k < m_dat.size(); k++) begin
                chk($sformatf("v%0d_pix%0d_data", i, k), int'(q_dat[k]), int'(m_dat[k]));
                chk($sformatf("v%0d_pix%0d_marks", i, k),
                    int'({q_sof[k], q_eol[k], q_eof[k]}), int'({m_sof[k], m_eol[k], m_eof[k]}));
            end
            if (i == 0) chk("first_pixel_latency", t_first_v - t_b1, 2);
        end

`ifdef CAM_TEST_PATTERN_EN
        // Window 0,0,4,2 is latched by the last pulse of the table loop
        clear_col();
        tpe = 1'b1;
        gen_frame(0); send_lines(); vs_pulse();
        tpe = 1'b0;
        chk("tpat_npix", q_dat.size(), 8);
        for (int k = 0; k < q_dat.size() && k < 8; k++)
            chk($sformatf("tpat_pix%0d", k), int'(q_dat[k]), (k % 4) ^ ((k / 4) << 4));
`endif

        // Reset in the middle of a line restarts the frame skip
        href = 1'b1;
        data = 8'h12;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_init_done", int'(init_done), 0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_line_err", int'(line_err), 0);
        href = 1'b0;
        data = 8'h00;
        rst_n = 1'b1;
        repeat (2) tick();
        clear_col();
        gen_frame(0); send_lines(); vs_pulse();
        chk("midrst_skip1_init_done", int'(init_done), 0);
        gen_frame(0); send_lines(); set_win(0); vs_pulse();
        chk("midrst_skip2_init_done", int'(init_done), 1);
        chk("midrst_skip_no_pixels", q_dat.size(), 0);
        clear_col();
        gen_frame(0); build_model(0); send_lines(); vs_pulse();
        chk("midrst_capture_npix", q_dat.size(), m_dat.size());
        if (q_dat.size() > 0 && m_dat.size() > 0)
            chk("midrst_capture_pix0", int'(q_dat[0]), int'(m_dat[0]));

        chk("markers_only_with_valid", n_badmark, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
